// File: rtl/battleship_scorer.sv
// battleship_scorer: shot scoring engine for a GRID x GRID battleship board.
// Holds a loadable ship map and a per-cell hit map. Shots arrive over a
// valid/ready handshake and are scanned one cell per clock. A normal shot
// covers one cell and a big shot covers a 3x3 footprint. Only new hits are
// scored. A running total is kept, and game over is flagged once every loaded
// ship cell has been hit.
//
// Ports:
//   clock, reset_L        rising-edge clock, asynchronous active-low reset
//   new_game              synchronous clear of maps, counters and big budget
//   ship_we/ship_X/ship_Y load one ship cell (IDLE only, 1-based coords)
//   shot_valid/shot_ready shot handshake; shot_X/shot_Y centre, shot_big 3x3
//   result_valid          one-cycle pulse with num_hits/result_big
//   total_hits            hits scored this game
//   ship_count            distinct ship cells loaded
//   big_left              big shots remaining
//   game_over             total_hits == ship_count != 0 (registered)
//
// Build option: define BATTLESHIP_BIG_EN to enable 3x3 big shots. When it is
// undefined, shot_big is ignored and big_left reads 0.
module battleship_scorer #(
  parameter int unsigned GRID      = 10,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned BIG_SHOTS = 2
) (
  input  logic                                clock,
  input  logic                                reset_L,
  input  logic                                new_game,
  input  logic                                ship_we,
  input  logic [COORD_W-1:0]                  ship_X,
  input  logic [COORD_W-1:0]                  ship_Y,
  input  logic                                shot_valid,
  output logic                                shot_ready,
  input  logic [COORD_W-1:0]                  shot_X,
  input  logic [COORD_W-1:0]                  shot_Y,
  input  logic                                shot_big,
  output logic                                result_valid,
  output logic [3:0]                          num_hits,
  output logic                                result_big,
  output logic [$clog2(GRID*GRID+1)-1:0]      total_hits,
  output logic [$clog2(GRID*GRID+1)-1:0]      ship_count,
  output logic [$clog2(BIG_SHOTS+1)-1:0]      big_left,
  output logic                                game_over
);

  localparam int unsigned CELLS = GRID * GRID;
  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam int unsigned CNT_W = $clog2(CELLS + 1);
  localparam int unsigned BL_W  = $clog2(BIG_SHOTS + 1);
  localparam int unsigned XW    = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   ship_map_q, ship_map_d;
  logic [CELLS-1:0]   hit_map_q, hit_map_d;
  logic [COORD_W-1:0] shot_x_q, shot_x_d;
  logic [COORD_W-1:0] shot_y_q, shot_y_d;
  logic [3:0]         shot_hits_q, shot_hits_d;
  logic [3:0]         num_hits_q, num_hits_d;
  logic               result_big_q, result_big_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               game_over_q, game_over_d;

`ifdef BATTLESHIP_BIG_EN
  logic               is_big_q, is_big_d;
  logic [1:0]         dx_q, dx_d;
  logic [1:0]         dy_q, dy_d;
  logic [BL_W-1:0]    big_left_q, big_left_d;
`else
  logic               unused_shot_big;
  assign unused_shot_big = shot_big;
`endif

  // Extra MSB keeps centre-1 from wrapping back onto the board:
  // 0-1 becomes all-ones, which is above GRID.
  logic [XW-1:0]      cell_x, cell_y;
  logic [IDX_W-1:0]   cell_idx, load_idx;
  logic               cell_on_board, load_on_board;
  logic               last_visit;

  function automatic logic in_range(input logic [XW-1:0] v);
    return (v >= XW'(1)) && (32'(v) <= GRID);
  endfunction

  function automatic logic [IDX_W-1:0] cell_index(input logic [XW-1:0] x, input logic [XW-1:0] y);
    return IDX_W'((32'(y) - 32'd1) * GRID + (32'(x) - 32'd1));
  endfunction

  always_comb begin
`ifdef BATTLESHIP_BIG_EN
    if (is_big_q) begin
      cell_x = {1'b0, shot_x_q} + XW'(dx_q) - XW'(1);
      cell_y = {1'b0, shot_y_q} + XW'(dy_q) - XW'(1);
    end else begin
      cell_x = {1'b0, shot_x_q};
      cell_y = {1'b0, shot_y_q};
    end
    last_visit = !is_big_q || (dx_q == 2'd2 && dy_q == 2'd2);
`else
    cell_x     = {1'b0, shot_x_q};
    cell_y     = {1'b0, shot_y_q};
    last_visit = 1'b1;
`endif
    cell_on_board = in_range(cell_x) && in_range(cell_y);
    cell_idx      = cell_index(cell_x, cell_y);
    load_on_board = in_range({1'b0, ship_X}) && in_range({1'b0, ship_Y});
    load_idx      = cell_index({1'b0, ship_X}, {1'b0, ship_Y});
  end

  assign shot_ready   = (state_q == IDLE) && !game_over_q;
  assign result_valid = (state_q == RESULT);
  assign num_hits     = num_hits_q;
  assign result_big   = result_big_q;
  assign total_hits   = total_q;
  assign ship_count   = count_q;
  assign game_over    = game_over_q;
`ifdef BATTLESHIP_BIG_EN
  assign big_left     = big_left_q;
`else
  assign big_left     = '0;
`endif

  always_comb begin
    state_d      = state_q;
    ship_map_d   = ship_map_q;
    hit_map_d    = hit_map_q;
    shot_x_d     = shot_x_q;
    shot_y_d     = shot_y_q;
    shot_hits_d  = shot_hits_q;
    num_hits_d   = num_hits_q;
    result_big_d = result_big_q;
    total_d      = total_q;
    count_d      = count_q;
    game_over_d  = (total_q == count_q) && (count_q != '0);
`ifdef BATTLESHIP_BIG_EN
    is_big_d     = is_big_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    big_left_d   = big_left_q;
`endif

    // Loads only happen in IDLE and scans only in SCAN, so both can update
    // the map in the same always_comb without colliding.
    if (ship_we && state_q == IDLE && load_on_board && !ship_map_q[load_idx]) begin
      ship_map_d[load_idx] = 1'b1;
      count_d              = count_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (shot_valid && shot_ready) begin
          shot_x_d    = shot_X;
          shot_y_d    = shot_Y;
          shot_hits_d = '0;
          state_d     = SCAN;
`ifdef BATTLESHIP_BIG_EN
          is_big_d    = shot_big && (big_left_q != '0);
          dx_d        = '0;
          dy_d        = '0;
          if (is_big_d) big_left_d = big_left_q - BL_W'(1);
`endif
        end
      end
      SCAN: begin
        if (cell_on_board && ship_map_q[cell_idx] && !hit_map_q[cell_idx]) begin
          hit_map_d[cell_idx] = 1'b1;
          shot_hits_d         = shot_hits_q + 4'd1;
          total_d             = total_q + CNT_W'(1);
        end
`ifdef BATTLESHIP_BIG_EN
        if (dx_q == 2'd2) begin
          dx_d = '0;
          dy_d = dy_q + 2'd1;
        end else begin
          dx_d = dx_q + 2'd1;
        end
`endif
        if (last_visit) begin
          num_hits_d = shot_hits_d;
`ifdef BATTLESHIP_BIG_EN
          result_big_d = is_big_q;
`else
          result_big_d = 1'b0;
`endif
          state_d = RESULT;
        end
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (new_game) begin
      state_d     = IDLE;
      ship_map_d  = '0;
      hit_map_d   = '0;
      shot_hits_d = '0;
      num_hits_d  = '0;
      total_d     = '0;
      count_d     = '0;
      game_over_d = 1'b0;
`ifdef BATTLESHIP_BIG_EN
      big_left_d  = BL_W'(BIG_SHOTS);
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      ship_map_q   <= '0;
      hit_map_q    <= '0;
      shot_x_q     <= '0;
      shot_y_q     <= '0;
      shot_hits_q  <= '0;
      num_hits_q   <= '0;
      result_big_q <= 1'b0;
      total_q      <= '0;
      count_q      <= '0;
      game_over_q  <= 1'b0;
`ifdef BATTLESHIP_BIG_EN
      is_big_q     <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      big_left_q   <= BL_W'(BIG_SHOTS);
`endif
    end else begin
      state_q      <= state_d;
      ship_map_q   <= ship_map_d;
      hit_map_q    <= hit_map_d;
      shot_x_q     <= shot_x_d;
      shot_y_q     <= shot_y_d;
      shot_hits_q  <= shot_hits_d;
      num_hits_q   <= num_hits_d;
      result_big_q <= result_big_d;
      total_q      <= total_d;
      count_q      <= count_d;
      game_over_q  <= game_over_d;
`ifdef BATTLESHIP_BIG_EN
      is_big_q     <= is_big_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      big_left_q   <= big_left_d;
`endif
    end
  end

endmodule

// File: tb/tb_battleship_scorer.sv
module tb_battleship_scorer;

  localparam int unsigned GRID      = 10;
  localparam int unsigned COORD_W   = 4;
  localparam int unsigned BIG_SHOTS = 2;
`ifdef BATTLESHIP_BIG_EN
  localparam int BIG_RST = 2;
`else
  localparam int BIG_RST = 0;
`endif

  logic               clock = 1'b0;
  logic               reset_L = 1'b0;
  logic               new_game = 1'b0;
  logic               ship_we = 1'b0;
  logic [COORD_W-1:0] ship_X = '0;
  logic [COORD_W-1:0] ship_Y = '0;
  logic               shot_valid = 1'b0;
  logic               shot_ready;
  logic [COORD_W-1:0] shot_X = '0;
  logic [COORD_W-1:0] shot_Y = '0;
  logic               shot_big = 1'b0;
  logic               result_valid;
  logic [3:0]         num_hits;
  logic               result_big;
  logic [6:0]         total_hits;
  logic [6:0]         ship_count;
  logic [1:0]         big_left;
  logic               game_over;

  battleship_scorer #(.GRID(GRID), .COORD_W(COORD_W), .BIG_SHOTS(BIG_SHOTS)) dut (
    .clock(clock), .reset_L(reset_L), .new_game(new_game), .ship_we(ship_we),
    .ship_X(ship_X), .ship_Y(ship_Y), .shot_valid(shot_valid), .shot_ready(shot_ready),
    .shot_X(shot_X), .shot_Y(shot_Y), .shot_big(shot_big), .result_valid(result_valid),
    .num_hits(num_hits), .result_big(result_big), .total_hits(total_hits),
    .ship_count(ship_count), .big_left(big_left), .game_over(game_over)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  int fx[19] = '{2, 2, 2,  7, 8, 2, 3, 4, 5, 6, 1, 2, 3, 4, 2, 3, 4, 9, 10};
  int fy[19] = '{8, 9, 10, 6, 6, 3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_ready"},    32'(shot_ready),   1);
    check({p, "_rvalid"},   32'(result_valid), 0);
    check({p, "_nhits"},    32'(num_hits),     0);
    check({p, "_rbig"},     32'(result_big),   0);
    check({p, "_total"},    32'(total_hits),   0);
    check({p, "_count"},    32'(ship_count),   0);
    check({p, "_bigleft"},  32'(big_left),     BIG_RST);
    check({p, "_gameover"}, 32'(game_over),    0);
  endtask

  task automatic load_fleet();
    for (int i = 0; i < 19; i++) begin
      ship_we = 1'b1;
      ship_X  = COORD_W'(fx[i]);
      ship_Y  = COORD_W'(fy[i]);
      @(negedge clock);
    end
    ship_we = 1'b0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
  endtask

  // Fires one shot and returns the latency (cycle N+lat after handshake edge N).
  task automatic fire(input int x, input int y, input logic big,
                      output int lat, output logic [3:0] nh, output logic rb);
    shot_X = COORD_W'(x);
    shot_Y = COORD_W'(y);
    shot_big = big;
    shot_valid = 1'b1;
    @(negedge clock);
    shot_valid = 1'b0;
    shot_big = 1'b0;
    lat = 1;
    while (result_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    nh = num_hits;
    rb = result_big;
    check("ready_low_in_result", 32'(shot_ready), 0);
    @(negedge clock);
    check("result_one_cycle", 32'(result_valid), 0);
  endtask

  task automatic watch_no_result(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (result_valid === 1'b1) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [3:0] nh;
    logic       rb;
    int         sum;

    // Reset
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    check_reset("rst");

    // Fleet load, duplicate and off-board loads
    load_fleet();
    check("fleet_count", 32'(ship_count), 19);
    ship_we = 1'b1; ship_X = 4'd2;  ship_Y = 4'd8; @(negedge clock);
    ship_X = 4'd0;  ship_Y = 4'd5; @(negedge clock);
    ship_X = 4'd11; ship_Y = 4'd3; @(negedge clock);
    ship_we = 1'b0;
    @(negedge clock);
    check("count_dup_oob", 32'(ship_count), 19);
    check("fleet_gameover", 32'(game_over), 0);

    // Normal shots
    fire(5, 3, 1'b0, lat, nh, rb);
    check("n53_lat", lat, 2);
    check("n53_hits", 32'(nh), 1);
    check("n53_big", 32'(rb), 0);
    check("n53_total", 32'(total_hits), 1);
    fire(5, 3, 1'b0, lat, nh, rb);
    check("n53_rep_hits", 32'(nh), 0);
    check("n53_rep_total", 32'(total_hits), 1);
    fire(5, 5, 1'b0, lat, nh, rb);
    check("miss_hits", 32'(nh), 0);
    fire(0, 0, 1'b0, lat, nh, rb);
    check("offboard_lat", lat, 2);
    check("offboard_hits", 32'(nh), 0);

`ifdef BATTLESHIP_BIG_EN
    pulse_new_game();
    load_fleet();
    fire(3, 2, 1'b1, lat, nh, rb);
    check("b32_lat", lat, 10);
    check("b32_hits", 32'(nh), 9);
    check("b32_big", 32'(rb), 1);
    check("b32_bigleft", 32'(big_left), 1);
    check("b32_total", 32'(total_hits), 9);

    pulse_new_game();
    load_fleet();
    fire(1, 1, 1'b1, lat, nh, rb);
    check("b11_hits", 32'(nh), 3);
    check("b11_total", 32'(total_hits), 3);
    check("b11_bigleft", 32'(big_left), 1);
    fire(10, 1, 1'b1, lat, nh, rb);
    check("b101_hits", 32'(nh), 2);
    check("b101_bigleft", 32'(big_left), 0);
    fire(7, 6, 1'b1, lat, nh, rb);
    check("b3rd_lat", lat, 2);
    check("b3rd_big", 32'(rb), 0);
    check("b3rd_hits", 32'(nh), 1);
    check("b3rd_bigleft", 32'(big_left), 0);
    check("b3rd_total", 32'(total_hits), 6);
`else
    fire(3, 2, 1'b1, lat, nh, rb);
    check("bigoff_lat", lat, 2);
    check("bigoff_big", 32'(rb), 0);
    check("bigoff_hits", 32'(nh), 1);
    check("bigoff_bigleft", 32'(big_left), 0);
    check("bigoff_total", 32'(total_hits), 2);
`endif

    // Sink the rest; reverse order so the final new hit is the last shot
    sum = 0;
    for (int i = 18; i >= 0; i--) begin
      fire(fx[i], fy[i], 1'b0, lat, nh, rb);
      sum += int'(nh);
    end
`ifdef BATTLESHIP_BIG_EN
    check("sweep_sum", sum, 13);
`else
    check("sweep_sum", sum, 17);
`endif
    check("end_total", 32'(total_hits), 19);
    check("end_gameover", 32'(game_over), 1);
    check("end_ready", 32'(shot_ready), 0);

    // Shots are refused once the game is over
    shot_X = 4'd1; shot_Y = 4'd1; shot_valid = 1'b1;
    watch_no_result("over_no_accept");
    shot_valid = 1'b0;
    check("over_total", 32'(total_hits), 19);

    // new_game clears everything
    pulse_new_game();
    check("ng_total", 32'(total_hits), 0);
    check("ng_count", 32'(ship_count), 0);
    check("ng_nhits", 32'(num_hits), 0);
    check("ng_gameover", 32'(game_over), 0);
    check("ng_bigleft", 32'(big_left), BIG_RST);
    check("ng_ready", 32'(shot_ready), 1);

    // Load and shot on the same cell in the same cycle; load during SCAN ignored
    ship_we = 1'b1; ship_X = 4'd5; ship_Y = 4'd5;
    shot_X = 4'd5; shot_Y = 4'd5; shot_big = 1'b0; shot_valid = 1'b1;
    @(negedge clock);
    shot_valid = 1'b0;
    ship_X = 4'd6; ship_Y = 4'd6;
    @(negedge clock);
    ship_we = 1'b0;
    check("sim_rvalid", 32'(result_valid), 1);
    check("sim_hits", 32'(num_hits), 1);
    @(negedge clock);
    check("sim_count", 32'(ship_count), 1);
    check("sim_total", 32'(total_hits), 1);
    check("sim_gameover", 32'(game_over), 1);
    check("sim_ready", 32'(shot_ready), 0);

    // new_game during a scan drops the shot
    pulse_new_game();
    load_fleet();
    shot_X = 4'd3; shot_Y = 4'd2; shot_big = 1'b1; shot_valid = 1'b1;
    @(negedge clock);
    shot_valid = 1'b0; shot_big = 1'b0;
`ifdef BATTLESHIP_BIG_EN
    repeat (3) @(negedge clock);
`endif
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    watch_no_result("ngscan_no_result");
    check("ngscan_total", 32'(total_hits), 0);
    check("ngscan_count", 32'(ship_count), 0);
    check("ngscan_bigleft", 32'(big_left), BIG_RST);
    check("ngscan_ready", 32'(shot_ready), 1);

    // Asynchronous reset during a scan
    load_fleet();
    shot_X = 4'd3; shot_Y = 4'd2; shot_big = 1'b1; shot_valid = 1'b1;
    @(negedge clock);
    shot_valid = 1'b0; shot_big = 1'b0;
`ifdef BATTLESHIP_BIG_EN
    repeat (3) @(negedge clock);
`endif
    reset_L = 1'b0;
    #1;
    check_reset("arst");
    @(negedge clock);
    reset_L = 1'b1;
    watch_no_result("arst_no_result");
    fire(3, 2, 1'b0, lat, nh, rb);
    check("arst_map_clear", 32'(nh), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
